// File: rtl/bcd_disp_pkg.sv
// Shared types and constants for the product BCD display block: FSM states,
// seven-segment patterns and the digit-code type used by the display mux.
package bcd_disp_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    CONVERT = 1'b1
  } state_t;

  // Digit codes 0-9 are decimal digits; 10 and 11 select minus and blank.
  typedef logic [3:0] digit_code_t;

  localparam digit_code_t CODE_MINUS = 4'd10;
  localparam digit_code_t CODE_BLANK = 4'd11;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Double-dabble correction: a nibble of 5 or more would exceed 9 after
  // the next shift, so pre-add 3 to carry into the next decade instead.
  function automatic logic [3:0] add3_if_ge5(input logic [3:0] n);
    return (n >= 4'd5) ? (n + 4'd3) : n;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational digit-code to active-low seven-segment decoder.
module seg7_decoder
  import bcd_disp_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  // Map each digit code to its segment pattern; unused codes stay blank.
  always_comb begin
    seg = SEG_BLANK;
    case (code)
      4'd0:       seg = SEG_0;
      4'd1:       seg = SEG_1;
      4'd2:       seg = SEG_2;
      4'd3:       seg = SEG_3;
      4'd4:       seg = SEG_4;
      4'd5:       seg = SEG_5;
      4'd6:       seg = SEG_6;
      4'd7:       seg = SEG_7;
      4'd8:       seg = SEG_8;
      4'd9:       seg = SEG_9;
      CODE_MINUS: seg = SEG_MINUS;
      default:    seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/product_bcd_display.sv
// Accepts signed 8-bit products over valid/ready, converts the magnitude to
// three BCD digits with a one-bit-per-cycle double-dabble engine, latches the
// result and scans it onto a 4-digit multiplexed seven-segment display.
module product_bcd_display
  import bcd_disp_pkg::*;
#(
  parameter int SCAN_DIV = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        prod_valid,
  input  logic [7:0]  prod,
  output logic        prod_ready,
  output logic        busy,
  output logic        bcd_valid,
  output logic        sign,
  output logic [11:0] bcd,
  output logic [3:0]  an,
  output logic [6:0]  seg
);

  localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  state_t            state_q, state_nxt;
  logic [3:0]        iter_cnt;
  logic [7:0]        mag;
  logic [11:0]       scratch;
  logic              sign_r;
  logic [11:0]       adj;
  logic [11:0]       scratch_nxt;
  logic [7:0]        mag_nxt;
  logic              accept;
  logic              last_iter;
  logic signed [7:0] prod_s;

  logic [DIV_W-1:0]  div_cnt;
  logic [1:0]        idx;
  digit_code_t       digit_code;
  logic [6:0]        seg_dec;

  // Magnitude of a signed byte as unsigned; -128 maps to 128 without overflow.
  function automatic logic [7:0] abs_mag(input logic signed [7:0] v);
    logic [7:0] u;
    u = v;
    return v[7] ? 8'(~u + 8'd1) : u;
  endfunction

  assign prod_s     = prod;
  assign prod_ready = (state_q == IDLE);
  assign busy       = (state_q == CONVERT);
  assign accept     = prod_valid && prod_ready;
  assign last_iter  = (state_q == CONVERT) && (iter_cnt == 4'd1);

  // One double-dabble step: correct each nibble, then shift {scratch, mag}.
  always_comb begin
    adj         = {add3_if_ge5(scratch[11:8]), add3_if_ge5(scratch[7:4]),
                   add3_if_ge5(scratch[3:0])};
    scratch_nxt = 12'({adj, mag[7]});
    mag_nxt     = {mag[6:0], 1'b0};
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_nxt;
  end

  // Next state: IDLE waits for a handshake, CONVERT runs eight iterations.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (prod_valid) state_nxt = CONVERT;
      CONVERT: if (iter_cnt == 4'd1) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Conversion datapath: load on handshake, iterate while converting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_r   <= 1'b0;
      mag      <= '0;
      scratch  <= '0;
      iter_cnt <= '0;
    end else if (accept) begin
      sign_r   <= prod[7];
      mag      <= abs_mag(prod_s);
      scratch  <= '0;
      iter_cnt <= 4'd8;
    end else if (state_q == CONVERT) begin
      scratch  <= scratch_nxt;
      mag      <= mag_nxt;
      iter_cnt <= iter_cnt - 4'd1;
    end
  end

  // Result registers: update only on the final iteration, pulse bcd_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd       <= '0;
      sign      <= 1'b0;
      bcd_valid <= 1'b0;
    end else begin
      bcd_valid <= last_iter;
      if (last_iter) begin
        bcd  <= scratch_nxt;
        sign <= sign_r;
      end
    end
  end

  // Free-running scan divider advancing the digit index every SCAN_DIV cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      idx     <= 2'd0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      idx     <= idx + 2'd1;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Digit mux with sign and leading-zero suppression on the upper digits.
  always_comb begin
    digit_code = CODE_BLANK;
    case (idx)
      2'd3: digit_code = sign ? CODE_MINUS : CODE_BLANK;
      2'd2: digit_code = (bcd[11:8] == 4'd0) ? CODE_BLANK : bcd[11:8];
      2'd1: digit_code = (bcd[11:4] == 8'd0) ? CODE_BLANK : bcd[7:4];
      default: digit_code = bcd[3:0];
    endcase
  end

  seg7_decoder u_seg7_decoder (
    .code (digit_code),
    .seg  (seg_dec)
  );

  // Registered display drive so anode and segment lines switch together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= 4'b1110;
      seg <= SEG_0;
    end else begin
      an  <= ~(4'b0001 << idx);
      seg <= seg_dec;
    end
  end

endmodule

// File: tb/tb_product_bcd_display.sv
// Self-checking bench for product_bcd_display with a scan divider of 4.
module tb_product_bcd_display;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        prod_valid = 1'b0;
  logic [7:0]  prod = 8'h00;
  logic        prod_ready, busy, bcd_valid, sign;
  logic [11:0] bcd;
  logic [3:0]  an;
  logic [6:0]  seg;

  int checks = 0;
  int failures = 0;

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};

  product_bcd_display #(.SCAN_DIV(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .prod_valid (prod_valid),
    .prod       (prod),
    .prod_ready (prod_ready),
    .busy       (busy),
    .bcd_valid  (bcd_valid),
    .sign       (sign),
    .bcd        (bcd),
    .an         (an),
    .seg        (seg)
  );

  always #5 clk = ~clk;

  // Reference model: decimal digits of |v| by plain arithmetic.
  function automatic int to_int(input logic [7:0] b);
    return int'($signed(b));
  endfunction

  function automatic logic [11:0] exp_bcd(input int v);
    int m;
    m = (v < 0) ? -v : v;
    return {4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  function automatic logic [6:0] exp_seg(input int pos, input int v);
    int m, h, t, o;
    m = (v < 0) ? -v : v;
    h = m / 100;
    t = (m / 10) % 10;
    o = m % 10;
    case (pos)
      3: return (v < 0) ? 7'b0111111 : 7'b1111111;
      2: return (h == 0) ? 7'b1111111 : seg_tab[h];
      1: return (h == 0 && t == 0) ? 7'b1111111 : seg_tab[t];
      default: return seg_tab[o];
    endcase
  endfunction

  function automatic int pos_of(input logic [3:0] a);
    case (a)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  // Drives one handshake and measures latency; returns at the negedge after
  // the bcd_valid pulse is seen (lat = -1 if it never came).
  task automatic run_conv(input logic [7:0] v, input logic [7:0] nextv,
                          input bit hold, output int lat, output int busyc,
                          output int early);
    logic [11:0] pb;
    logic ps;
    lat = -1; busyc = 0; early = 0;
    @(negedge clk);
    prod = v;
    prod_valid = 1'b1;
    for (int i = 0; i < 30 && !prod_ready; i++) @(negedge clk);
    pb = bcd;
    ps = sign;
    @(posedge clk);
    @(negedge clk);
    if (busy && !prod_ready) busyc++;
    if (hold) prod = nextv;
    else begin
      prod_valid = 1'b0;
      prod = 8'($urandom);
    end
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (!hold) prod = 8'($urandom);
      if (bcd_valid) begin
        lat = k;
        break;
      end
      if (busy && !prod_ready) busyc++;
      if (bcd !== pb || sign !== ps) early++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (prod_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got %b want 1", prod_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (bcd_valid !== 1'b0) begin failures++; $display("FAIL reset_bcd_valid got %b want 0", bcd_valid); end
    checks++; if (sign !== 1'b0) begin failures++; $display("FAIL reset_sign got %b want 0", sign); end
    checks++; if (bcd !== 12'h000) begin failures++; $display("FAIL reset_bcd got %h want 000", bcd); end
    checks++; if (an !== 4'b1110) begin failures++; $display("FAIL reset_an got %b want 1110", an); end
    checks++; if (seg !== 7'b1000000) begin failures++; $display("FAIL reset_seg got %b want 1000000", seg); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_conversions();
    logic [7:0] vals [20];
    int lat, busyc, early, v, p;
    logic [3:0] seen;
    vals[0] = 8'h80; vals[1] = 8'h31; vals[2] = 8'hFF; vals[3] = 8'h00;
    for (int i = 4; i < 20; i++) vals[i] = 8'($urandom);
    for (int i = 0; i < 20; i++) begin
      v = to_int(vals[i]);
      run_conv(vals[i], 8'h00, 1'b0, lat, busyc, early);
      checks++; if (lat != 8) begin failures++; $display("FAIL conv_latency prod=%h got %0d want 8", vals[i], lat); end
      checks++; if (busyc != 8) begin failures++; $display("FAIL conv_ready_low prod=%h got %0d want 8", vals[i], busyc); end
      checks++; if (early != 0) begin failures++; $display("FAIL conv_stale prod=%h early_changes=%0d want 0", vals[i], early); end
      checks++; if (bcd !== exp_bcd(v)) begin failures++; $display("FAIL conv_bcd prod=%h got %h want %h", vals[i], bcd, exp_bcd(v)); end
      checks++; if (sign !== (v < 0)) begin failures++; $display("FAIL conv_sign prod=%h got %b want %b", vals[i], sign, (v < 0)); end
      checks++; if (prod_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL conv_idle prod=%h ready=%b busy=%b want 1/0", vals[i], prod_ready, busy); end
      @(negedge clk);
      checks++; if (bcd_valid !== 1'b0) begin failures++; $display("FAIL conv_pulse_width prod=%h got %b want 0", vals[i], bcd_valid); end
      seen = 4'b0000;
      for (int c = 0; c < 17; c++) begin
        @(negedge clk);
        p = pos_of(an);
        checks++;
        if (p < 0) begin
          failures++; $display("FAIL disp_an prod=%h an=%b want one-hot-zero", vals[i], an);
        end else begin
          seen[p] = 1'b1;
          if (seg !== exp_seg(p, v)) begin
            failures++; $display("FAIL disp_seg prod=%h digit=%0d got %b want %b", vals[i], p, seg, exp_seg(p, v));
          end
        end
      end
      checks++; if (seen !== 4'b1111) begin failures++; $display("FAIL disp_cover prod=%h seen=%b want 1111", vals[i], seen); end
    end
  endtask

  task automatic test_back_to_back();
    int lat, busyc, early, lat2;
    run_conv(8'h40, 8'hC0, 1'b1, lat, busyc, early);
    checks++; if (lat != 8) begin failures++; $display("FAIL b2b_lat1 got %0d want 8", lat); end
    checks++; if (bcd !== 12'h064 || sign !== 1'b0) begin failures++; $display("FAIL b2b_first got %b/%h want 0/064", sign, bcd); end
    checks++; if (prod_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready got %b want 1", prod_ready); end
    lat2 = -1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) begin
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_second_accept busy=%b want 1", busy); end
      end
      if (bcd_valid) begin
        lat2 = k;
        break;
      end
    end
    checks++; if (lat2 != 9) begin failures++; $display("FAIL b2b_lat2 got %0d want 9", lat2); end
    checks++; if (bcd !== 12'h064 || sign !== 1'b1) begin failures++; $display("FAIL b2b_second got %b/%h want 1/064", sign, bcd); end
    prod_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int lat, busyc, early, pulses;
    @(negedge clk);
    prod = 8'h55;
    prod_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    prod_valid = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bcd !== 12'h000 || sign !== 1'b0) begin failures++; $display("FAIL rstmid_result got %b/%h want 0/000", sign, bcd); end
    checks++; if (prod_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL rstmid_ctrl ready=%b busy=%b want 1/0", prod_ready, busy); end
    checks++; if (bcd_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got %b want 0", bcd_valid); end
    pulses = 0;
    repeat (2) begin
      @(negedge clk);
      if (bcd_valid) pulses++;
    end
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (bcd_valid) pulses++;
    end
    checks++; if (pulses != 0) begin failures++; $display("FAIL rstmid_no_pulse got %0d want 0", pulses); end
    run_conv(8'h55, 8'h00, 1'b0, lat, busyc, early);
    checks++; if (lat != 8) begin failures++; $display("FAIL rstmid_relat got %0d want 8", lat); end
    checks++; if (bcd !== 12'h085 || sign !== 1'b0) begin failures++; $display("FAIL rstmid_reconv got %b/%h want 0/085", sign, bcd); end
  endtask

  task automatic test_scan();
    logic [3:0] prev;
    int run, changes, p, pp;
    prev = an;
    run = 0;
    changes = 0;
    for (int c = 0; c < 48; c++) begin
      @(negedge clk);
      run++;
      p = pos_of(an);
      if (an !== prev) begin
        pp = pos_of(prev);
        checks++;
        if (p < 0 || pp < 0 || p != ((pp + 1) % 4)) begin
          failures++; $display("FAIL scan_order got %b after %b", an, prev);
        end
        if (changes > 0) begin
          checks++; if (run != 4) begin failures++; $display("FAIL scan_period got %0d want 4", run); end
        end
        changes++;
        run = 0;
        prev = an;
      end
      if (p >= 0) begin
        checks++; if (seg !== exp_seg(p, 85)) begin failures++; $display("FAIL scan_seg digit=%0d got %b want %b", p, seg, exp_seg(p, 85)); end
      end
    end
    checks++; if (changes < 10) begin failures++; $display("FAIL scan_changes got %0d want >=10", changes); end
  endtask

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    test_reset();
    test_conversions();
    test_back_to_back();
    test_reset_mid();
    test_scan();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/product_bcd_display.md
# product_bcd_display

Output stage that sits directly downstream of the 4x4 signed Booth multiplier. It accepts each 8-bit signed product through a valid/ready handshake and converts its magnitude to three BCD digits with a sequential double-dabble engine. It latches sign and digits for downstream logic and drives a 4-digit multiplexed seven-segment display with the result, for example "-128" or "  49".

## Interface
- `SCAN_DIV`, default 16: clock cycles each digit stays enabled during display scan; legal values are 2 and up.
- `clk`, input, 1: rising-edge clock.
- `rst_n`, input, 1: reset. Asynchronous and active-low.
- `prod_valid`, input, 1: the upstream product is valid.
- `prod`, input, 8: signed two's-complement product.
- `prod_ready`, output, 1: the block can accept a product. High only in IDLE.
- `busy`, output, 1: a conversion is in progress (CONVERT state).
- `bcd_valid`, output, 1: one-cycle pulse when `sign`/`bcd` update.
- `sign`, output, 1: latched sign; 1 means negative.
- `bcd`, output, 12: latched magnitude as {hundreds, tens, ones}, each a BCD nibble.
- `an`, output, 4: digit enables, active-low, one-hot-zero. Bit 0 is the rightmost digit.
- `seg`, output, 7: segments {g,f,e,d,c,b,a}, active-low.

## Operation
- **States:** IDLE and CONVERT.
- **Accept (IDLE):** a handshake occurs when `prod_valid && prod_ready` at a rising edge.
  - Capture `sign_r = prod[7]`.
  - Capture `mag = |prod|` as 8-bit unsigned. -128 gives 128; no overflow is possible.
  - Clear the 12-bit scratch register, load an iteration counter with 8, and go to CONVERT.
- **CONVERT:** one double-dabble iteration per cycle.
  - Add 3 to each scratch nibble that is >= 5.
  - Then shift {scratch, mag} left by one.
  - Decrement the counter.
  - After the 8th iteration:
    - write the final scratch value to `bcd` and `sign_r` to `sign`;
    - assert `bcd_valid` for exactly one cycle;
    - return to IDLE.
- **Input sampling:** `prod` is sampled only at the handshake edge. `prod_valid` seen outside IDLE is ignored, and the producer holds `prod_valid` until ready. The multiplier output is combinational, so `prod` may change freely while not handshaking.
- **Display scan:**
  - A free-running divider advances a 2-bit digit index every `SCAN_DIV` cycles, cycling 0,1,2,3,0…
  - `an` is the active-low one-hot of the index.
  - Scanning is independent of conversion, and the display always shows the latched `sign`/`bcd`.
- **Digit content:**
  - Digit 3 shows '-' when `sign` is 1, else blank.
  - Digit 2 shows hundreds; blank if hundreds = 0.
  - Digit 1 shows tens; blank if hundreds = 0 and tens = 0.
  - Digit 0 always shows ones.
- **Segment codes (active-low, {g..a}):**
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - '-'=0111111, blank=1111111
- **Zero result:** a product of 0 always gives `sign` = 0.

## Timing
- **Reset values (asynchronous, immediate on `rst_n` low):**
  - state IDLE, so `prod_ready` = 1 and `busy` = 0;
  - `bcd_valid` = 0, `sign` = 0, `bcd` = 0x000;
  - scan divider 0, index 0, so `an` = 1110 and `seg` = 1000000 (shows "0").
- **Latency:** handshake at edge E0; iterations on E1..E8. `bcd`/`sign` update and `bcd_valid` rises at E8, and `bcd_valid` falls at E9.
- **Ready:** `prod_ready` is low from E0 to E8 and high again after E8. The earliest next handshake is E9, giving throughput of one product per 9 cycles.
- **Stale results:** `bcd`/`sign` keep the previous result throughout a conversion. There are no partial updates on outputs.
- **Reset mid-conversion:** aborts the conversion, clears scratch and outputs to reset values, and emits no `bcd_valid`.
- **Output registering:** `an`/`seg` are registered and change one cycle after the index changes. `prod_ready`/`busy` decode directly from state.

## Structure
- Shared package `bcd_disp_pkg` holds:
  - the state enum (IDLE, CONVERT);
  - the seven-segment constants (digits 0-9, MINUS, BLANK);
  - a 4-bit digit-code type, where codes 10 and 11 mean minus and blank.
- Sub-module `seg7_decoder`: combinational, 4-bit digit code to 7-bit active-low segments. It is instantiated once after the digit mux.
- The top level holds the handshake FSM, the double-dabble datapath, the result registers, the scan divider and the digit mux.

## Test plan
- **-128:** `prod` = 0x80 handshake at E0. Expect `bcd_valid` pulse at E8, `sign` = 1, `bcd` = 0x128. The scanned digits (an 0111,1011,1101,1110) show '-', 1, 2, 8.
- **49 (7*7):** `prod` = 0x31. Expect `sign` = 0, `bcd` = 0x049. Display shows blank, blank, 4, 9 with leading-zero suppression.
- **-1 and 0:** `prod` = 0xFF gives `sign` = 1, `bcd` = 0x001, display "-  1". Then `prod` = 0x00 gives `sign` = 0, `bcd` = 0x000, display "   0".
- **Back-to-back with held valid:** `prod_valid` is held high and `prod` switches from 0x40 to 0xC0 while busy. Expect the first result 0x064/+ at E8. The second handshake occurs at E9 (not earlier) and gives 0x064/- at E17. Confirm the values changed while busy were ignored.
- **Reset mid-conversion:** `rst_n` pulled low at E4 of a 0x55 conversion. Expect immediate `bcd` = 0x000, `sign` = 0, `prod_ready` = 1 and no `bcd_valid`. After release, 0x55 converts to 0x085 normally.
- **Scan with `SCAN_DIV` = 4:** `an` steps through 1110, 1101, 1011, 0111 every 4 cycles and wraps, and `seg` matches the digit each time.
